// File: rtl/msi_pkg.sv
// Shared encodings for the MSI request stage and its line storage.
//   ST_*  : per-line coherence state as seen by the MSI block (I/S/M)
//   WR_*  : WriteRead codes presented to the MSI block
//   HM_*  : HitMiss codes presented to the MSI block
//   ctrl_state_e : request controller FSM
package msi_pkg;

   localparam logic [2:0] ST_I = 3'b001;
   localparam logic [2:0] ST_S = 3'b010;
   localparam logic [2:0] ST_M = 3'b011;

   localparam logic [1:0] WR_READ  = 2'b00;
   localparam logic [1:0] WR_WRITE = 2'b01;
   localparam logic [1:0] WR_IDLE  = 2'b10;

   localparam logic [1:0] HM_MISS = 2'b00;
   localparam logic [1:0] HM_HIT  = 2'b01;

   typedef enum logic [2:0] {
      FSM_IDLE,
      FSM_LOOKUP,
      FSM_EVAL,
      FSM_WB,
      FSM_FILL,
      FSM_COMMIT
   } ctrl_state_e;

   // 000 is not a legal line state; the MSI block may emit it for "no
   // change requested" situations, so it collapses to Invalid.
   function automatic logic [2:0] legal_state(input logic [2:0] s);
      return (s == 3'b000) ? ST_I : s;
   endfunction

endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped line storage: per-line state, tag and one data word.
//   clk, rst_n            : clock, async active-low reset (state=I, tag/data=0)
//   rd_idx                : combinational read index
//   rd_state/tag/data     : contents of the indexed line
//   wr_idx                : single write port index
//   wr_state_en/wr_state  : state field write
//   wr_tag_en/wr_tag      : tag field write
//   wr_data_en/wr_data    : data field write
module msi_line_array
   import msi_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int INDEX_W   = 2,
   parameter int TAG_W     = 6,
   parameter int DATA_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic [2:0]         rd_state,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic               wr_state_en,
   input  logic [2:0]         wr_state,
   input  logic               wr_tag_en,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic               wr_data_en,
   input  logic [DATA_W-1:0]  wr_data
);

   logic [NUM_LINES-1:0][2:0]        state_q, state_d;
   logic [NUM_LINES-1:0][TAG_W-1:0]  tag_q,   tag_d;
   logic [NUM_LINES-1:0][DATA_W-1:0] data_q,  data_d;

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_state_en) state_d[wr_idx] = wr_state;
      if (wr_tag_en)   tag_d[wr_idx]   = wr_tag;
      if (wr_data_en)  data_d[wr_idx]  = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            state_q[i] <= ST_I;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign rd_state = state_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/msi_cache_line_ctrl.sv
// Upstream request stage for the MSI coherence block. Accepts one CPU
// request at a time, presents it to the MSI block for a single LOOKUP
// cycle, captures the MSI decision, runs memory write-back / fill and
// commits the new line state before answering the CPU.
//   Clock, Resetn                 : clock, async active-low reset
//   CpuReq*/CpuResp*              : CPU request / one-cycle response
//   WriteRead, HitMiss, StateCache: to MSI block (valid in LOOKUP only)
//   NewStateCache, WriteBackIn,
//   InvalidateIn                  : from MSI block, sampled at end of LOOKUP
//   MemWb*                        : victim write-back handshake
//   MemRd*                        : line fill handshake
//   DirInvalidate                 : one-cycle pulse in COMMIT on invalidate hit
module msi_cache_line_ctrl
   import msi_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int NUM_LINES = 4,
   parameter int DATA_W    = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              CpuReqValid,
   output logic              CpuReqReady,
   input  logic              CpuReqWrite,
   input  logic [ADDR_W-1:0] CpuReqAddr,
   input  logic [DATA_W-1:0] CpuReqData,
   output logic              CpuRespValid,
   output logic              CpuRespHit,
   output logic [DATA_W-1:0] CpuRespData,
   output logic [1:0]        WriteRead,
   output logic [1:0]        HitMiss,
   output logic [2:0]        StateCache,
   input  logic [2:0]        NewStateCache,
   input  logic [1:0]        WriteBackIn,
   input  logic [1:0]        InvalidateIn,
   output logic              MemWbValid,
   output logic [ADDR_W-1:0] MemWbAddr,
   output logic [DATA_W-1:0] MemWbData,
   input  logic              MemWbAck,
   output logic              MemRdValid,
   output logic [ADDR_W-1:0] MemRdAddr,
   input  logic              MemRdAck,
   input  logic [DATA_W-1:0] MemRdData,
   output logic              DirInvalidate
);

   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int TAG_W   = ADDR_W - INDEX_W;

   ctrl_state_e       fsm_q,   fsm_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic              wr_q,    wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        nsc_q,   nsc_d;
   logic              wb_q,    wb_d;
   logic              inv_q,   inv_d;
   logic              hit_q,   hit_d;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   req_tag;
   logic [2:0]         line_state;
   logic [TAG_W-1:0]   line_tag;
   logic [DATA_W-1:0]  line_data;
   logic               hit_now;

   logic               arr_state_en;
   logic               arr_tag_en;
   logic               arr_data_en;
   logic [DATA_W-1:0]  arr_data;

   assign idx     = addr_q[INDEX_W-1:0];
   assign req_tag = addr_q[ADDR_W-1:INDEX_W];
   assign hit_now = (line_tag == req_tag) && (line_state != ST_I);

   msi_line_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_W   (INDEX_W),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W)
   ) u_lines (
      .clk         (Clock),
      .rst_n       (Resetn),
      .rd_idx      (idx),
      .rd_state    (line_state),
      .rd_tag      (line_tag),
      .rd_data     (line_data),
      .wr_idx      (idx),
      .wr_state_en (arr_state_en),
      .wr_state    (legal_state(nsc_q)),
      .wr_tag_en   (arr_tag_en),
      .wr_tag      (req_tag),
      .wr_data_en  (arr_data_en),
      .wr_data     (arr_data)
   );

   always_comb begin
      fsm_d   = fsm_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      nsc_d   = nsc_q;
      wb_d    = wb_q;
      inv_d   = inv_q;
      hit_d   = hit_q;
      unique case (fsm_q)
         FSM_IDLE: begin
            if (CpuReqValid) begin
               addr_d  = CpuReqAddr;
               wr_d    = CpuReqWrite;
               wdata_d = CpuReqData;
               fsm_d   = FSM_LOOKUP;
            end
         end
         FSM_LOOKUP: begin
            // MSI block has settled by now; freeze its decision.
            nsc_d = NewStateCache;
            wb_d  = (WriteBackIn == 2'b01);
            inv_d = (InvalidateIn == 2'b01);
            hit_d = hit_now;
            fsm_d = FSM_EVAL;
         end
         FSM_EVAL: begin
            if (wb_q)        fsm_d = FSM_WB;
            else if (!hit_q) fsm_d = FSM_FILL;
            else             fsm_d = FSM_COMMIT;
         end
         FSM_WB: begin
            if (MemWbAck) fsm_d = hit_q ? FSM_COMMIT : FSM_FILL;
         end
         FSM_FILL: begin
            if (MemRdAck) fsm_d = FSM_COMMIT;
         end
         FSM_COMMIT: fsm_d = FSM_IDLE;
         default:    fsm_d = FSM_IDLE;
      endcase
   end

   // Fill writes tag+data; commit writes state and, for writes, data.
   // The two never coincide, so one array port suffices.
   always_comb begin
      arr_state_en = (fsm_q == FSM_COMMIT);
      arr_tag_en   = (fsm_q == FSM_FILL) && MemRdAck;
      arr_data_en  = arr_tag_en || ((fsm_q == FSM_COMMIT) && wr_q);
      arr_data     = (fsm_q == FSM_COMMIT) ? wdata_q : MemRdData;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         fsm_q   <= FSM_IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         nsc_q   <= ST_I;
         wb_q    <= 1'b0;
         inv_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         nsc_q   <= nsc_d;
         wb_q    <= wb_d;
         inv_q   <= inv_d;
         hit_q   <= hit_d;
      end
   end

   // Outputs decode straight from the FSM so reset takes effect at once.
   // Outside LOOKUP the MSI-facing bus looks like an idle, invalid line.
   always_comb begin
      CpuReqReady   = (fsm_q == FSM_IDLE);
      WriteRead     = WR_IDLE;
      HitMiss       = HM_MISS;
      StateCache    = ST_I;
      MemWbValid    = 1'b0;
      MemWbAddr     = '0;
      MemWbData     = '0;
      MemRdValid    = 1'b0;
      MemRdAddr     = '0;
      CpuRespValid  = 1'b0;
      CpuRespHit    = 1'b0;
      CpuRespData   = '0;
      DirInvalidate = 1'b0;
      unique case (fsm_q)
         FSM_LOOKUP: begin
            WriteRead  = wr_q ? WR_WRITE : WR_READ;
            HitMiss    = hit_now ? HM_HIT : HM_MISS;
            StateCache = line_state;
         end
         FSM_WB: begin
            MemWbValid = 1'b1;
            MemWbAddr  = {line_tag, idx};
            MemWbData  = line_data;
         end
         FSM_FILL: begin
            MemRdValid = 1'b1;
            MemRdAddr  = addr_q;
         end
         FSM_COMMIT: begin
            CpuRespValid  = 1'b1;
            CpuRespHit    = hit_q;
            CpuRespData   = wr_q ? '0 : line_data;
            DirInvalidate = inv_q;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/msi_cache_line_ctrl.md
Name: msi_cache_line_ctrl

Overview:
- Upstream request stage for the MSI coherence state machine (maquinaDeEstado).
- Owns a small direct-mapped cache: per-line state, tag and data. It accepts CPU read/write requests and presents WriteRead, HitMiss and the line's current stateCache to the MSI block for exactly one cycle.
- Captures the MSI block's newStateCache, WriteBack and invalidate results, then runs the memory write-back and fill handshakes.
- Commits the new line state and returns a response to the CPU.

Parameters:
- ADDR_W, 8: CPU address width.
- NUM_LINES, 4: number of cache lines; must be a power of 2. INDEX_W = log2(NUM_LINES). TAG_W = ADDR_W - INDEX_W.
- DATA_W, 8: data word width; one word per line.

Ports:
- Clock  in  1  single clock; all state updates on posedge.
- Resetn  in  1  asynchronous, active-low reset.
- CpuReqValid  in  1  CPU request valid.
- CpuReqReady  out  1  high only in IDLE.
- CpuReqWrite  in  1  1 = write, 0 = read.
- CpuReqAddr  in  ADDR_W  request address; index = low INDEX_W bits.
- CpuReqData  in  DATA_W  write data.
- CpuRespValid  out  1  one-cycle response pulse.
- CpuRespHit  out  1  request hit (tag match and state != I).
- CpuRespData  out  DATA_W  read data; 0 for writes.
- WriteRead  out  2  to MSI block: 00 read, 01 write, 10 idle.
- HitMiss  out  2  to MSI block: 01 hit, 00 miss.
- StateCache  out  3  to MSI block: line state (I=001, S=010, M=011).
- NewStateCache  in  3  from MSI block.
- WriteBackIn  in  2  from MSI block, 01 = write-back required.
- InvalidateIn  in  2  from MSI block, 01 = invalidate hit.
- MemWbValid  out  1  write-back request, held until MemWbAck.
- MemWbAddr  out  ADDR_W  {old tag, index}.
- MemWbData  out  DATA_W  old line data.
- MemWbAck  in  1  write-back accepted.
- MemRdValid  out  1  fill request, held until MemRdAck.
- MemRdAddr  out  ADDR_W  latched request address.
- MemRdAck  in  1  fill data valid.
- MemRdData  in  DATA_W  fill data.
- DirInvalidate  out  1  one-cycle pulse in COMMIT if captured InvalidateIn == 01.

Behaviour:
- Reset (Resetn low, asynchronous):
  - FSM goes to IDLE; every line state = 001 (I); tags and data = 0.
  - Outputs: WriteRead=10, HitMiss=00, StateCache=001, all valid/pulse outputs 0, CpuReqReady=1, data/address outputs 0.
  - Any in-flight request and handshake is dropped.
- States: IDLE, LOOKUP, EVAL, WB, FILL, COMMIT.
- IDLE:
  - WriteRead=10, so no MSI condition can match.
  - On CpuReqValid: latch addr, write flag and data, go to LOOKUP. Requests are accepted only in IDLE.
- LOOKUP (exactly 1 cycle):
  - WriteRead = {1'b0, write}.
  - HitMiss = 01 if stored tag == request tag and state != 001, else 00.
  - StateCache = stored state of the indexed line, regardless of tag.
  - The MSI block evaluates on the negedge inside this cycle. Go to EVAL.
- EVAL:
  - WriteRead returns to 10.
  - Capture NewStateCache, WriteBackIn, InvalidateIn and the hit flag on entry (posedge ending LOOKUP).
  - Next state: WB if WriteBackIn == 01; else FILL if miss; else COMMIT.
- WB:
  - MemWbValid=1 with {stored tag, index} and stored data, held stable until MemWbAck.
  - On ack: go to FILL if miss, else COMMIT.
- FILL:
  - MemRdValid=1 with the latched address, held until MemRdAck.
  - On ack: write MemRdData and the request tag into the line, go to COMMIT.
- COMMIT (1 cycle):
  - Line state = captured NewStateCache.
  - On a write, line data = latched write data.
  - CpuRespValid=1; CpuRespHit = captured hit; CpuRespData = line data after fill for reads, 0 for writes.
  - DirInvalidate pulses if captured InvalidateIn == 01. Go to IDLE.
- Latency (CpuReqValid accepted → CpuRespValid):
  - Hit: 3 cycles.
  - Miss: 3 cycles + fill ack wait (FILL ≥ 1 cycle).
  - Write-back: adds WB ≥ 1 cycle.
- Boundary cases:
  - MemWbAck or MemRdAck outside its state: ignored.
  - Ack in the same cycle valid rises: accepted, 1-cycle WB/FILL.
  - Back-to-back requests to the same line see the committed state.
  - Captured NewStateCache == 000 is written as 001.

Decomposition:
- Shared package msi_pkg:
  - State encodings ST_I=001, ST_S=010, ST_M=011.
  - WriteRead codes WR_READ=00, WR_WRITE=01, WR_IDLE=10.
  - HitMiss codes HM_MISS=00, HM_HIT=01.
  - Controller FSM enum.
- One sub-module: msi_line_array (state/tag/data storage, async-reset state bits, one write port, combinational read by index).

Test Plan:
- Reset then read 0x05 → LOOKUP shows StateCache=001, HitMiss=00, WriteRead=00; MemRdValid with addr 0x05; ack data 0xAA → CpuRespData=0xAA, hit=0, line 1 state=010.
- Repeat read 0x05 → HitMiss=01, no memory traffic, response in 3 cycles, data 0xAA, state stays 010.
- Write 0x05 data 0x3C while line is S → WriteRead=01, HitMiss=01; line becomes 011 with data 0x3C; DirInvalidate pulses; no memory traffic.
- Read 0x09 (same index, different tag) while line is M:
  - WriteBackIn=01 → MemWbValid with addr 0x05, data 0x3C.
  - Then fill from 0x09.
  - Line ends with state 010 and tag of 0x09.
- Hold MemRdAck low for 5 cycles → MemRdValid and MemRdAddr stay stable, CpuReqReady=0; a new CpuReqValid is not accepted.
- Assert Resetn low during WB → all outputs return to reset values immediately; every line reads state 001 afterwards.
